gray_bin_conv_pipe: RTL and testbench

Parametrised, pipelined bidirectional Gray/binary code converter with valid/ready handshaking on both sides.
- Per-transfer mode select: Gray->binary or binary->Gray.
- Gray-sequence adjacency checker and an accepted-transfer counter.
- Sits between Gray-coded sources (encoders, CDC pointers, counters) and binary consumers, or the reverse.

---
 rtl/gray_pkg.sv | 38 +++
 rtl/gray_pipe_stage.sv | 55 +++++
 rtl/gray_bin_conv_pipe.sv | 111 +++++++++++
 tb/tb_gray_bin_conv_pipe.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared constants and width-generic code-conversion helpers for the Gray/binary converter.
// Helpers operate on a 32-bit container; narrower words are zero-extended by the caller.
package gray_pkg;

    localparam int  MAX_W    = 32;
    localparam int  POP_W    = 6;
    localparam logic MODE_G2B = 1'b0;
    localparam logic MODE_B2G = 1'b1;

    // Zero-extension above the real MSB leaves the low bits of the prefix-XOR untouched.
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        logic [MAX_W-1:0] g;
        g[MAX_W-1] = b[MAX_W-1];
        for (int i = 0; i < MAX_W - 1; i++) begin
            g[i] = b[i] ^ b[i+1];
        end
        return g;
    endfunction

    function automatic logic [POP_W-1:0] popcount(input logic [MAX_W-1:0] v);
        logic [POP_W-1:0] c;
        c = '0;
        for (int i = 0; i < MAX_W; i++) begin
            c = c + {{(POP_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/gray_pipe_stage.sv
// One valid/ready register slice carrying a converted word and the mode that produced it.
// The slice loads when empty or when its downstream neighbour takes the current word.
module gray_pipe_stage
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             up_mode,
    input  logic             dn_load,
    output logic             load,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             mode
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             mode_q, mode_d;

    always_comb begin
        load    = !valid_q || dn_load;
        valid_d = valid_q;
        data_d  = data_q;
        mode_d  = mode_q;
        if (load) begin
            valid_d = up_valid;
            if (up_valid) begin
                data_d = up_data;
                mode_d = up_mode;
            end
        end
    end

    // Data is cleared as well so the block output reads zero straight after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            mode_q  <= MODE_G2B;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign mode  = mode_q;

endmodule

// File: rtl/gray_bin_conv_pipe.sv
// Pipelined bidirectional Gray/binary converter with valid/ready on both sides,
// a sticky Gray-adjacency checker for mode-0 input and an accepted-transfer counter.
module gray_bin_conv_pipe
    import gray_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode,
    output logic             adj_err,
    output logic [CNT_W-1:0] xfer_cnt
);

    // Index 0 is the converter output feeding stage 1; index STAGES is the block output.
    logic             st_valid [0:STAGES];
    logic [WIDTH-1:0] st_data  [0:STAGES];
    logic             st_mode  [0:STAGES];
    logic             st_load  [1:STAGES+1];

    logic [WIDTH-1:0] conv_data;
    logic             in_xfer;

    logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
    logic             prev_vld_q, prev_vld_d;
    logic             adj_err_q, adj_err_d;
    logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

    always_comb begin
        conv_data = '0;
        if (in_mode == MODE_G2B) begin
            conv_data = WIDTH'(gray2bin(MAX_W'(in_data)));
        end else begin
            conv_data = WIDTH'(bin2gray(MAX_W'(in_data)));
        end
    end

    assign st_valid[0]       = in_valid;
    assign st_data[0]        = conv_data;
    assign st_mode[0]        = in_mode;
    assign st_load[STAGES+1] = out_ready;

    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
        gray_pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .up_valid (st_valid[k-1]),
            .up_data  (st_data[k-1]),
            .up_mode  (st_mode[k-1]),
            .dn_load  (st_load[k+1]),
            .load     (st_load[k]),
            .valid    (st_valid[k]),
            .data     (st_data[k]),
            .mode     (st_mode[k])
        );
    end

    // Gating with rst keeps both handshakes idle during the reset cycle itself.
    assign in_ready  = st_load[1] && !rst;
    assign in_xfer   = in_valid && in_ready;
    assign out_valid = st_valid[STAGES] && !rst;
    assign out_data  = st_data[STAGES];
    assign out_mode  = st_mode[STAGES];

    always_comb begin
        prev_gray_d = prev_gray_q;
        prev_vld_d  = prev_vld_q;
        adj_err_d   = adj_err_q;
        xfer_cnt_d  = xfer_cnt_q;
        if (in_xfer) begin
            xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
            if (in_mode == MODE_G2B) begin
                // Distance 0 counts as an error too: a Gray source must step by exactly one bit.
                if (prev_vld_q && (popcount(MAX_W'(in_data ^ prev_gray_q)) != POP_W'(1))) begin
                    adj_err_d = 1'b1;
                end
                prev_gray_d = in_data;
                prev_vld_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_gray_q <= '0;
            prev_vld_q  <= 1'b0;
            adj_err_q   <= 1'b0;
            xfer_cnt_q  <= '0;
        end else begin
            prev_gray_q <= prev_gray_d;
            prev_vld_q  <= prev_vld_d;
            adj_err_q   <= adj_err_d;
            xfer_cnt_q  <= xfer_cnt_d;
        end
    end

    assign adj_err  = adj_err_q;
    assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_gray_bin_conv_pipe.sv
// Directed, table-driven bench for gray_bin_conv_pipe at WIDTH=4, STAGES=2.
module tb_gray_bin_conv_pipe;

    localparam int WIDTH  = 4;
    localparam int STAGES = 2;
    localparam int CNT_W  = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_mode;
    logic             adj_err;
    logic [CNT_W-1:0] xfer_cnt;

    gray_bin_conv_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mode  (out_mode),
        .adj_err   (adj_err),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       mode;
        logic [3:0] din;
        logic [3:0] dout;
        logic       err;
    } vec_t;

    vec_t tbl [15];
    int   n_pass  = 0;
    int   n_total = 0;
    logic [3:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Gray code of a 4-bit binary value, for the long streaming runs.
    function automatic logic [3:0] to_gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // One word per cycle with out_ready high; word j must appear exactly two edges later.
    task automatic run_table(input int start, input int n);
        out_ready = 1'b1;
        for (int j = 0; j <= n + 1; j++) begin
            if (j < n) begin
                in_valid = 1'b1;
                in_mode  = tbl[start+j].mode;
                in_data  = tbl[start+j].din;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (j < n) chk("tbl_in_ready", 32'(in_ready), 32'd1);
            if (j < 2) begin
                chk("tbl_out_valid_lat", 32'(out_valid), 32'd0);
            end else begin
                chk("tbl_out_valid", 32'(out_valid), 32'd1);
                chk($sformatf("tbl_out_data[%0d]", start + j - 2), 32'(out_data), 32'(tbl[start+j-2].dout));
                chk($sformatf("tbl_out_mode[%0d]", start + j - 2), 32'(out_mode), 32'(tbl[start+j-2].mode));
            end
            tick();
            if (j < n) chk($sformatf("tbl_adj_err[%0d]", start + j), 32'(adj_err), 32'(tbl[start+j].err));
        end
        in_valid = 1'b0;
    endtask

    int k;
    int n_in;
    int n_out;
    logic [3:0] bp_words [2];

    initial begin
        // Mode-0 Gray count sequence
        tbl[0]  = '{1'b0, 4'b0000, 4'b0000, 1'b0};
        tbl[1]  = '{1'b0, 4'b0001, 4'b0001, 1'b0};
        tbl[2]  = '{1'b0, 4'b0011, 4'b0010, 1'b0};
        tbl[3]  = '{1'b0, 4'b0010, 4'b0011, 1'b0};
        tbl[4]  = '{1'b0, 4'b0110, 4'b0100, 1'b0};
        // Mode-0 with a distance-2 jump
        tbl[5]  = '{1'b0, 4'b1111, 4'b1010, 1'b0};
        tbl[6]  = '{1'b0, 4'b1100, 4'b1000, 1'b1};
        tbl[7]  = '{1'b0, 4'b0101, 4'b0110, 1'b1};
        // Mode-1 conversions, error flag stays as it was
        tbl[8]  = '{1'b1, 4'b1010, 4'b1111, 1'b1};
        tbl[9]  = '{1'b1, 4'b0111, 4'b0100, 1'b1};
        tbl[10] = '{1'b1, 4'b1000, 4'b1100, 1'b1};
        // Mode-1 word between mode-0 words must not disturb prev_gray; then a repeat word
        tbl[11] = '{1'b0, 4'b0001, 4'b0001, 1'b0};
        tbl[12] = '{1'b1, 4'b1111, 4'b1000, 1'b0};
        tbl[13] = '{1'b0, 4'b0011, 4'b0010, 1'b0};
        tbl[14] = '{1'b0, 4'b0011, 4'b0010, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready_hold", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_mode", 32'(out_mode), 32'd0);
        chk("rst_adj_err", 32'(adj_err), 32'd0);
        chk("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        tick();

        run_table(0, 5);
        chk("t1_xfer_cnt", 32'(xfer_cnt), 32'd5);
        chk("t1_adj_err", 32'(adj_err), 32'd0);

        do_reset();
        run_table(5, 3);
        run_table(8, 3);
        chk("t3_xfer_cnt", 32'(xfer_cnt), 32'd6);

        do_reset();
        run_table(11, 4);

        // Backpressure: only two words fit, the head word holds steady
        bp_words[0] = 4'b0110;
        bp_words[1] = 4'b1001;
        out_ready = 1'b0;
        in_mode   = 1'b1;
        k = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = (k < 2) ? bp_words[k] : 4'b1111;
            #1;
            chk($sformatf("bp_in_ready[%0d]", c), 32'(in_ready), 32'(c < 2));
            if (c >= 2) begin
                chk("bp_out_valid", 32'(out_valid), 32'd1);
                chk("bp_out_hold", 32'(out_data), 32'b0101);
            end
            if (in_ready) k++;
            tick();
        end
        in_valid = 1'b0;
        chk("bp_accepted", 32'(k), 32'd2);
        out_ready = 1'b1;
        #1;
        chk("bp_drain0_valid", 32'(out_valid), 32'd1);
        chk("bp_drain0_data", 32'(out_data), 32'b0101);
        tick();
        chk("bp_drain1_valid", 32'(out_valid), 32'd1);
        chk("bp_drain1_data", 32'(out_data), 32'b1101);
        tick();
        chk("bp_drain_empty", 32'(out_valid), 32'd0);

        // Full pipeline streaming: simultaneous in and out each cycle
        out_ready = 1'b0;
        in_mode   = 1'b1;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1;
            in_data  = 4'(c);
            #1;
            if (in_ready) exp_q.push_back(to_gray(4'(c)));
            tick();
        end
        chk("full_fill", 32'(exp_q.size()), 32'd2);
        n_in  = 0;
        n_out = 0;
        out_ready = 1'b1;
        for (int c = 2; c < 12; c++) begin
            in_valid = 1'b1;
            in_data  = 4'(c);
            #1;
            chk($sformatf("full_in_ready[%0d]", c), 32'(in_ready), 32'd1);
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) chk("full_underflow", 32'd1, 32'd0);
                else chk("full_order", 32'(out_data), 32'(exp_q.pop_front()));
            end
            if (in_valid && in_ready) begin
                n_in++;
                exp_q.push_back(to_gray(4'(c)));
            end
            tick();
        end
        in_valid = 1'b0;
        chk("full_n_in", 32'(n_in), 32'd10);
        chk("full_n_out", 32'(n_out), 32'd10);
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
            #1;
            if (out_valid) chk("full_drain_order", 32'(out_data), 32'(exp_q.pop_front()));
            tick();
        end
        chk("full_drain_left", 32'(exp_q.size()), 32'd0);
        #1;
        chk("full_drain_empty", 32'(out_valid), 32'd0);
        tick();

        // Reset with two words in flight
        out_ready = 1'b0;
        in_mode   = 1'b0;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1;
            in_data  = (c == 0) ? 4'b0001 : 4'b0011;
            #1;
            tick();
        end
        chk("mid_out_valid_pre", 32'(out_valid), 32'd1);
        chk("mid_adj_err_pre", 32'(adj_err), 32'd1);
        rst       = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("mid_out_valid", 32'(out_valid), 32'd0);
        chk("mid_xfer_cnt", 32'(xfer_cnt), 32'd0);
        chk("mid_adj_err", 32'(adj_err), 32'd0);
        chk("mid_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = 4'b1111;
        tick();
        in_valid = 1'b0;
        chk("post_first_adj_err", 32'(adj_err), 32'd0);
        tick();
        chk("post_out_valid", 32'(out_valid), 32'd1);
        chk("post_out_data", 32'(out_data), 32'b1010);
        chk("post_xfer_cnt", 32'(xfer_cnt), 32'd1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
